// File: rtl/llc_mem_adapter_pkg.sv
// rtl/llc_mem_adapter_pkg.sv - shared constants, types and FSM state for llc_mem_adapter
package llc_mem_adapter_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int BITS_PER_WORD  = 64;
  localparam int ADDR_BITS      = 32;
  localparam int LINE_BYTES     = WORDS_PER_LINE * BITS_PER_WORD / 8;
  localparam int LINE_ADDR_BITS = ADDR_BITS - $clog2(LINE_BYTES);

  typedef logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] line_t;
  typedef logic [BITS_PER_WORD-1:0]                word_t;
  typedef logic [LINE_ADDR_BITS-1:0]               line_addr_t;
  typedef logic [1:0]                              hprot_t;
  typedef logic [2:0]                              hsize_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_ADDR,
    RD_BEAT,
    RSP
  } llc_mem_adapter_state_t;

endpackage

// File: rtl/llc_mem_adapter.sv
// rtl/llc_mem_adapter.sv - line-to-word memory bus converter, single outstanding request
module llc_mem_adapter #(
  parameter int WORDS_PER_LINE = llc_mem_adapter_pkg::WORDS_PER_LINE,
  parameter int BITS_PER_WORD  = llc_mem_adapter_pkg::BITS_PER_WORD,
  parameter int ADDR_BITS      = llc_mem_adapter_pkg::ADDR_BITS,
  parameter int LINE_ADDR_BITS = ADDR_BITS - $clog2(WORDS_PER_LINE * BITS_PER_WORD / 8)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    llc_mem_req_valid,
  output logic                                    llc_mem_req_ready,
  input  logic                                    llc_mem_req_hwrite,
  input  logic [2:0]                              llc_mem_req_hsize,
  input  logic [1:0]                              llc_mem_req_hprot,
  input  logic [LINE_ADDR_BITS-1:0]               llc_mem_req_addr,
  input  logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] llc_mem_req_line,
  output logic                                    llc_mem_rsp_valid,
  input  logic                                    llc_mem_rsp_ready,
  output logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] llc_mem_rsp_line,
  output logic                                    mem_req_valid,
  input  logic                                    mem_req_ready,
  output logic                                    mem_req_write,
  output logic [ADDR_BITS-1:0]                    mem_req_addr,
  output logic [2:0]                              mem_req_hsize,
  output logic [1:0]                              mem_req_hprot,
  output logic [BITS_PER_WORD-1:0]                mem_req_data,
  output logic                                    mem_req_last,
  input  logic                                    mem_rsp_valid,
  output logic                                    mem_rsp_ready,
  input  logic [BITS_PER_WORD-1:0]                mem_rsp_data,
  input  logic                                    mem_rsp_last,
  output logic                                    protocol_err
);

  import llc_mem_adapter_pkg::*;

  localparam int LINE_W        = WORDS_PER_LINE * BITS_PER_WORD;
  localparam int CNT_W         = $clog2(WORDS_PER_LINE);
  localparam int WORD_OFF_BITS = $clog2(BITS_PER_WORD / 8);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_LINE - 1);

  llc_mem_adapter_state_t state_q, state_d;

  logic [CNT_W-1:0]          cnt_q;
  logic [LINE_ADDR_BITS-1:0] addr_q;
  logic [LINE_W-1:0]         line_q;
  logic [2:0]                hsize_q;
  logic [1:0]                hprot_q;
  logic                      perr_q;
  logic                      cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and state-decoded handshake outputs
  always_comb begin
    state_d           = state_q;
    llc_mem_req_ready = 1'b0;
    llc_mem_rsp_valid = 1'b0;
    mem_req_valid     = 1'b0;
    mem_req_write     = 1'b0;
    mem_req_last      = 1'b0;
    mem_rsp_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        // held low while reset is applied so the LLC cannot hand over a line
        llc_mem_req_ready = rst;
        if (llc_mem_req_valid) state_d = llc_mem_req_hwrite ? WR_BEAT : RD_ADDR;
      end
      WR_BEAT: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_last  = cnt_last;
        if (mem_req_ready && cnt_last) state_d = IDLE;
      end
      RD_ADDR: begin
        mem_req_valid = 1'b1;
        mem_req_last  = 1'b1;
        if (mem_req_ready) state_d = RD_BEAT;
      end
      RD_BEAT: begin
        mem_rsp_ready = 1'b1;
        // completion is counted, the bus last flag only feeds protocol_err
        if (mem_rsp_valid && cnt_last) state_d = RSP;
      end
      RSP: begin
        llc_mem_rsp_valid = 1'b1;
        if (llc_mem_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, beat counter, shared line buffer and sticky protocol flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      hsize_q <= '0;
      hprot_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (llc_mem_req_valid) begin
            addr_q  <= llc_mem_req_addr;
            line_q  <= llc_mem_req_line;
            hsize_q <= llc_mem_req_hsize;
            hprot_q <= llc_mem_req_hprot;
            cnt_q   <= '0;
          end
        end
        WR_BEAT: if (mem_req_ready) cnt_q <= cnt_q + CNT_W'(1);
        RD_ADDR: if (mem_req_ready) cnt_q <= '0;
        RD_BEAT: begin
          if (mem_rsp_valid) begin
            line_q[cnt_q*BITS_PER_WORD +: BITS_PER_WORD] <= mem_rsp_data;
            cnt_q <= cnt_q + CNT_W'(1);
            if (mem_rsp_last != cnt_last) perr_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Beat address walks words within the line; fills use cnt=0 so they land on word 0
  assign mem_req_addr     = {addr_q, cnt_q, {WORD_OFF_BITS{1'b0}}};
  assign mem_req_data     = (state_q == WR_BEAT) ? line_q[cnt_q*BITS_PER_WORD +: BITS_PER_WORD]
                                                 : '0;
  assign mem_req_hsize    = hsize_q;
  assign mem_req_hprot    = hprot_q;
  assign llc_mem_rsp_line = line_q;
  assign protocol_err     = perr_q;

endmodule

// File: tb/tb_llc_mem_adapter.sv
// tb/tb_llc_mem_adapter.sv - self-checking bench for llc_mem_adapter
module tb_llc_mem_adapter;
  import llc_mem_adapter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       llc_mem_req_valid, llc_mem_req_ready, llc_mem_req_hwrite;
  logic [2:0] llc_mem_req_hsize;
  logic [1:0] llc_mem_req_hprot;
  line_addr_t llc_mem_req_addr;
  line_t      llc_mem_req_line;
  logic       llc_mem_rsp_valid, llc_mem_rsp_ready;
  line_t      llc_mem_rsp_line;
  logic       mem_req_valid, mem_req_ready, mem_req_write, mem_req_last;
  logic [31:0] mem_req_addr;
  logic [2:0] mem_req_hsize;
  logic [1:0] mem_req_hprot;
  word_t      mem_req_data;
  logic       mem_rsp_valid, mem_rsp_ready, mem_rsp_last;
  word_t      mem_rsp_data;
  logic       protocol_err;

  llc_mem_adapter dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(llc_mem_req_valid), .llc_mem_req_ready(llc_mem_req_ready),
    .llc_mem_req_hwrite(llc_mem_req_hwrite), .llc_mem_req_hsize(llc_mem_req_hsize),
    .llc_mem_req_hprot(llc_mem_req_hprot), .llc_mem_req_addr(llc_mem_req_addr),
    .llc_mem_req_line(llc_mem_req_line),
    .llc_mem_rsp_valid(llc_mem_rsp_valid), .llc_mem_rsp_ready(llc_mem_rsp_ready),
    .llc_mem_rsp_line(llc_mem_rsp_line),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_hsize(mem_req_hsize), .mem_req_hprot(mem_req_hprot),
    .mem_req_data(mem_req_data), .mem_req_last(mem_req_last),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_last(mem_rsp_last),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // observed bus request beats
  logic [31:0] ob_addr[$];
  word_t       ob_data[$];
  bit          ob_last[$];
  bit          ob_write[$];
  logic [2:0]  ob_hsize;
  logic [1:0]  ob_hprot;
  line_t       ob_line;
  int          stab_viol;
  int          cur_n, first_beat_n;
  bit          stalled;
  logic [31:0] st_addr;
  word_t       st_data;
  bit          st_last, st_write;
  bit          err_exp;
  line_t       last_fill_exp;

  function automatic logic [31:0] exp_beat_addr(line_addr_t a, int i);
    return 32'(a) * LINE_BYTES + 32'(i) * (BITS_PER_WORD / 8);
  endfunction

  function automatic word_t word_of(line_t l, int i);
    return l[i*BITS_PER_WORD +: BITS_PER_WORD];
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int j = 0; j < WORDS_PER_LINE * BITS_PER_WORD / 32; j++) l[j*32 +: 32] = $urandom;
    return l;
  endfunction

  // bus slave for request beats, called once per falling edge
  task automatic bus_req_side(input bit bp);
    bit rdy;
    if (stalled && (!mem_req_valid || mem_req_addr !== st_addr || mem_req_data !== st_data ||
                    mem_req_last !== st_last || mem_req_write !== st_write))
      stab_viol++;
    stalled = 1'b0;
    if (mem_req_valid) begin
      rdy = bp ? ($urandom_range(1, 0) == 1) : 1'b1;
      if (rdy) begin
        if (ob_addr.size() == 0) begin
          first_beat_n = cur_n;
          ob_hsize = mem_req_hsize;
          ob_hprot = mem_req_hprot;
        end
        ob_addr.push_back(mem_req_addr);
        ob_data.push_back(mem_req_data);
        ob_last.push_back(mem_req_last);
        ob_write.push_back(mem_req_write);
      end else begin
        stalled = 1'b1;
        st_addr = mem_req_addr; st_data = mem_req_data;
        st_last = mem_req_last; st_write = mem_req_write;
      end
      mem_req_ready = rdy;
    end else begin
      mem_req_ready = 1'b0;
    end
  endtask

  task automatic clear_obs();
    ob_addr.delete(); ob_data.delete(); ob_last.delete(); ob_write.delete();
    stab_viol = 0; stalled = 1'b0; first_beat_n = -1; ob_line = '0;
  endtask

  // lat: falling edges from accept until llc_mem_req_ready returns
  task automatic run_write(input line_addr_t a, input line_t l, input logic [2:0] hs,
                           input logic [1:0] hp, input bit bp, output int lat);
    clear_obs();
    lat = -1;
    @(negedge clk);
    llc_mem_req_valid = 1'b1; llc_mem_req_hwrite = 1'b1; llc_mem_req_addr = a;
    llc_mem_req_line = l; llc_mem_req_hsize = hs; llc_mem_req_hprot = hp;
    @(negedge clk);
    llc_mem_req_valid = 1'b0; llc_mem_req_line = '0;
    for (int n = 1; n < 300; n++) begin
      cur_n = n;
      if (llc_mem_req_ready) begin lat = n; break; end
      bus_req_side(bp);
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
  endtask

  // lat: falling edges from final data beat until llc_mem_rsp_valid; -1 if never completed
  task automatic run_fill(input line_addr_t a, input line_t d, input logic [3:0] mask,
                          input logic [2:0] hs, input logic [1:0] hp, input bit bp,
                          input int hold, output int lat);
    int k, n_last, h;
    bit done, seen;
    line_t first;
    k = 0; n_last = -100; h = hold; done = 1'b0; seen = 1'b0; first = '0;
    clear_obs();
    lat = -1;
    @(negedge clk);
    llc_mem_req_valid = 1'b1; llc_mem_req_hwrite = 1'b0; llc_mem_req_addr = a;
    llc_mem_req_line = rand_line(); llc_mem_req_hsize = hs; llc_mem_req_hprot = hp;
    @(negedge clk);
    llc_mem_req_valid = 1'b0;
    for (int n = 1; n < 400 && !done; n++) begin
      cur_n = n;
      bus_req_side(bp);
      if (llc_mem_rsp_valid) begin
        if (!seen) begin seen = 1'b1; first = llc_mem_rsp_line; lat = n - n_last; end
        else if (llc_mem_rsp_line !== first) stab_viol++;
        ob_line = llc_mem_rsp_line;
        mem_rsp_valid = 1'b0;
        if (h > 0) begin h--; llc_mem_rsp_ready = 1'b0; end
        else begin llc_mem_rsp_ready = 1'b1; done = 1'b1; end
      end else if (mem_rsp_ready && k < WORDS_PER_LINE && (!bp || $urandom_range(1, 0) == 1)) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = word_of(d, k); mem_rsp_last = mask[k];
        k++; n_last = n;
      end else begin
        mem_rsp_valid = 1'b0; mem_rsp_data = {$urandom, $urandom}; mem_rsp_last = $urandom_range(1, 0);
      end
      @(negedge clk);
    end
    llc_mem_rsp_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (llc_mem_req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready: got %b want 0", llc_mem_req_ready); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req_valid: got %b want 0", mem_req_valid); end
    vectors++; if (llc_mem_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 0", llc_mem_rsp_valid); end
    vectors++; if (mem_rsp_ready !== 1'b0) begin miscompares++; $display("FAIL rst_mem_rsp_ready: got %b want 0", mem_rsp_ready); end
    vectors++; if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL rst_perr: got %b want 0", protocol_err); end
    vectors++; if (llc_mem_rsp_line !== '0) begin miscompares++; $display("FAIL rst_rsp_line: got %h want 0", llc_mem_rsp_line); end
    vectors++; if (mem_req_data !== '0) begin miscompares++; $display("FAIL rst_req_data: got %h want 0", mem_req_data); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (llc_mem_req_ready !== 1'b1) begin miscompares++; $display("FAIL post_rst_req_ready: got %b want 1", llc_mem_req_ready); end
  endtask

  task automatic test_write_basic();
    line_t l; int lat;
    for (int i = 0; i < WORDS_PER_LINE; i++) l[i*BITS_PER_WORD +: BITS_PER_WORD] = {32'hA0A0_A0A0, 32'(i)};
    run_write(27'h1234, l, 3'd3, 2'd1, 1'b0, lat);
    vectors++; if (ob_addr.size() != WORDS_PER_LINE) begin miscompares++; $display("FAIL wr_beats: got %0d want %0d", ob_addr.size(), WORDS_PER_LINE); end
    vectors++; if (lat != 5) begin miscompares++; $display("FAIL wr_ready_latency: got %0d want 5", lat); end
    vectors++; if (first_beat_n != 1) begin miscompares++; $display("FAIL wr_first_beat: got %0d want 1", first_beat_n); end
    vectors++; if (ob_hsize !== 3'd3 || ob_hprot !== 2'd1) begin miscompares++; $display("FAIL wr_hsize_hprot: got %0d/%0d want 3/1", ob_hsize, ob_hprot); end
    for (int i = 0; i < ob_addr.size() && i < WORDS_PER_LINE; i++) begin
      vectors++; if (ob_addr[i] !== exp_beat_addr(27'h1234, i)) begin miscompares++; $display("FAIL wr_addr[%0d]: got %h want %h", i, ob_addr[i], exp_beat_addr(27'h1234, i)); end
      vectors++; if (ob_data[i] !== word_of(l, i)) begin miscompares++; $display("FAIL wr_data[%0d]: got %h want %h", i, ob_data[i], word_of(l, i)); end
      vectors++; if (ob_last[i] !== (i == WORDS_PER_LINE - 1)) begin miscompares++; $display("FAIL wr_last[%0d]: got %b want %b", i, ob_last[i], i == WORDS_PER_LINE - 1); end
      vectors++; if (ob_write[i] !== 1'b1) begin miscompares++; $display("FAIL wr_write[%0d]: got %b want 1", i, ob_write[i]); end
    end
  endtask

  task automatic test_fill_basic();
    line_t d; int lat;
    for (int i = 0; i < WORDS_PER_LINE; i++) d[i*BITS_PER_WORD +: BITS_PER_WORD] = {32'hD0D0_D0D0, 32'(i)};
    run_fill(27'h40, d, 4'b1000, 3'd2, 2'd2, 1'b0, 0, lat);
    vectors++; if (ob_addr.size() != 1) begin miscompares++; $display("FAIL rd_addr_beats: got %0d want 1", ob_addr.size()); end
    if (ob_addr.size() > 0) begin
      vectors++; if (ob_addr[0] !== exp_beat_addr(27'h40, 0)) begin miscompares++; $display("FAIL rd_addr: got %h want %h", ob_addr[0], exp_beat_addr(27'h40, 0)); end
      vectors++; if (ob_write[0] !== 1'b0 || ob_last[0] !== 1'b1) begin miscompares++; $display("FAIL rd_write_last: got %b%b want 01", ob_write[0], ob_last[0]); end
    end
    vectors++; if (first_beat_n != 1) begin miscompares++; $display("FAIL rd_first_beat: got %0d want 1", first_beat_n); end
    vectors++; if (ob_line !== d) begin miscompares++; $display("FAIL rd_line: got %h want %h", ob_line, d); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL rd_rsp_latency: got %0d want 1", lat); end
    vectors++; if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL rd_perr: got %b want 0", protocol_err); end
    vectors++; if (llc_mem_req_ready !== 1'b1 || llc_mem_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_back_idle: got ready=%b rsp_valid=%b want 1/0", llc_mem_req_ready, llc_mem_rsp_valid); end
  endtask

  task automatic test_backpressure();
    line_t l, d; int lat;
    l = rand_line(); d = rand_line();
    run_write(27'h2_0F0F, l, 3'd1, 2'd3, 1'b1, lat);
    vectors++; if (ob_addr.size() != WORDS_PER_LINE) begin miscompares++; $display("FAIL bp_wr_beats: got %0d want %0d", ob_addr.size(), WORDS_PER_LINE); end
    vectors++; if (stab_viol != 0) begin miscompares++; $display("FAIL bp_wr_stable: got %0d violations want 0", stab_viol); end
    for (int i = 0; i < ob_addr.size() && i < WORDS_PER_LINE; i++) begin
      vectors++; if (ob_data[i] !== word_of(l, i) || ob_addr[i] !== exp_beat_addr(27'h2_0F0F, i)) begin miscompares++; $display("FAIL bp_wr_beat[%0d]: got %h@%h want %h@%h", i, ob_data[i], ob_addr[i], word_of(l, i), exp_beat_addr(27'h2_0F0F, i)); end
    end
    run_fill(27'h3_1111, d, 4'b1000, 3'd0, 2'd0, 1'b1, 5, lat);
    last_fill_exp = d;
    vectors++; if (ob_line !== d) begin miscompares++; $display("FAIL bp_rd_line: got %h want %h", ob_line, d); end
    vectors++; if (stab_viol != 0) begin miscompares++; $display("FAIL bp_rd_stable: got %0d violations want 0", stab_viol); end
    vectors++; if (ob_addr.size() != 1) begin miscompares++; $display("FAIL bp_rd_addr_beats: got %0d want 1", ob_addr.size()); end
  endtask

  task automatic test_idle_rsp();
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_last = 1'b1; mem_rsp_data = {$urandom, $urandom};
      @(negedge clk);
      vectors++; if (mem_rsp_ready !== 1'b0) begin miscompares++; $display("FAIL idle_rsp_ready[%0d]: got %b want 0", i, mem_rsp_ready); end
      vectors++; if (llc_mem_req_ready !== 1'b1 || mem_req_valid !== 1'b0 || llc_mem_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL idle_state[%0d]: got rdy=%b mv=%b rv=%b want 1/0/0", i, llc_mem_req_ready, mem_req_valid, llc_mem_rsp_valid); end
    end
    mem_rsp_valid = 1'b0; mem_rsp_last = 1'b0;
    vectors++; if (llc_mem_rsp_line !== last_fill_exp) begin miscompares++; $display("FAIL idle_buffer: got %h want %h", llc_mem_rsp_line, last_fill_exp); end
    vectors++; if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL idle_perr: got %b want 0", protocol_err); end
  endtask

  task automatic test_protocol_err();
    line_t d, l; int lat;
    d = rand_line(); l = rand_line();
    run_fill(27'h55, d, 4'b0010, 3'd3, 2'd0, 1'b0, 0, lat);
    vectors++; if (ob_line !== d) begin miscompares++; $display("FAIL perr_line: got %h want %h", ob_line, d); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL perr_count_complete: got %0d want 1", lat); end
    vectors++; if (protocol_err !== 1'b1) begin miscompares++; $display("FAIL perr_set: got %b want 1", protocol_err); end
    run_write(27'h56, l, 3'd3, 2'd0, 1'b0, lat);
    vectors++; if (protocol_err !== 1'b1) begin miscompares++; $display("FAIL perr_sticky: got %b want 1", protocol_err); end
  endtask

  task automatic test_reset_mid_write();
    line_t l, d; int lat;
    l = rand_line(); d = rand_line();
    @(negedge clk);
    llc_mem_req_valid = 1'b1; llc_mem_req_hwrite = 1'b1; llc_mem_req_addr = 27'h0ABC; llc_mem_req_line = l;
    @(negedge clk);
    llc_mem_req_valid = 1'b0; mem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    mem_req_ready = 1'b0;
    vectors++; if (mem_req_valid !== 1'b1 || mem_req_data !== word_of(l, 2) || mem_req_addr !== exp_beat_addr(27'h0ABC, 2)) begin miscompares++; $display("FAIL mid_wr_beat2: got v=%b %h@%h want 1 %h@%h", mem_req_valid, mem_req_data, mem_req_addr, word_of(l, 2), exp_beat_addr(27'h0ABC, 2)); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (mem_req_valid !== 1'b0 || llc_mem_rsp_valid !== 1'b0 || mem_rsp_ready !== 1'b0 || llc_mem_req_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_valids: got %b%b%b%b want 0000", mem_req_valid, llc_mem_rsp_valid, mem_rsp_ready, llc_mem_req_ready); end
    vectors++; if (mem_req_data !== '0 || llc_mem_rsp_line !== '0 || protocol_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_data: got data=%h line=%h perr=%b want zeros", mem_req_data, llc_mem_rsp_line, protocol_err); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++; if (llc_mem_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_release: got rdy=%b mv=%b want 1/0", llc_mem_req_ready, mem_req_valid); end
    err_exp = 1'b0;
    run_fill(27'h0ABD, d, 4'b1000, 3'd3, 2'd1, 1'b0, 0, lat);
    vectors++; if (ob_line !== d || lat != 1) begin miscompares++; $display("FAIL mid_rst_fill: got %h lat %0d want %h lat 1", ob_line, lat, d); end
    vectors++; if (protocol_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_fill_perr: got %b want 0", protocol_err); end
  endtask

  task automatic test_random();
    line_t l; line_addr_t a; logic [3:0] mask; logic [2:0] hs; logic [1:0] hp;
    bit bp; int lat; int nexp;
    for (int t = 0; t < 20; t++) begin
      l = rand_line(); a = line_addr_t'($urandom); hs = 3'($urandom); hp = 2'($urandom);
      bp = ($urandom_range(1, 0) == 1);
      if ($urandom_range(1, 0) == 1) begin
        run_write(a, l, hs, hp, bp, lat);
        vectors++; if (ob_addr.size() != WORDS_PER_LINE || stab_viol != 0 || lat < 0) begin miscompares++; $display("FAIL rnd_wr[%0d]: got beats=%0d viol=%0d lat=%0d want %0d/0/>=0", t, ob_addr.size(), stab_viol, lat, WORDS_PER_LINE); end
        nexp = 0;
        for (int i = 0; i < ob_addr.size() && i < WORDS_PER_LINE; i++)
          if (ob_addr[i] !== exp_beat_addr(a, i) || ob_data[i] !== word_of(l, i) ||
              ob_last[i] !== (i == WORDS_PER_LINE - 1) || ob_write[i] !== 1'b1) nexp++;
        vectors++; if (nexp != 0 || ob_hsize !== hs || ob_hprot !== hp) begin miscompares++; $display("FAIL rnd_wr_beats[%0d]: got %0d bad beats hs=%0d hp=%0d want 0 hs=%0d hp=%0d", t, nexp, ob_hsize, ob_hprot, hs, hp); end
      end else begin
        mask = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'b1000;
        err_exp = err_exp | (mask != 4'b1000);
        run_fill(a, l, mask, hs, hp, bp, $urandom_range(3, 0), lat);
        vectors++; if (ob_line !== l || lat != 1) begin miscompares++; $display("FAIL rnd_rd_line[%0d]: got %h lat %0d want %h lat 1", t, ob_line, lat, l); end
        vectors++; if (ob_addr.size() != 1 || (ob_addr.size() == 1 && ob_addr[0] !== exp_beat_addr(a, 0)) || stab_viol != 0) begin miscompares++; $display("FAIL rnd_rd_req[%0d]: got beats=%0d viol=%0d want 1 beat at %h", t, ob_addr.size(), stab_viol, exp_beat_addr(a, 0)); end
      end
      vectors++; if (protocol_err !== err_exp) begin miscompares++; $display("FAIL rnd_perr[%0d]: got %b want %b", t, protocol_err, err_exp); end
    end
  endtask

  initial begin
    llc_mem_req_valid = 1'b0; llc_mem_req_hwrite = 1'b0; llc_mem_req_hsize = '0;
    llc_mem_req_hprot = '0; llc_mem_req_addr = '0; llc_mem_req_line = '0;
    llc_mem_rsp_ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_data = '0; mem_rsp_last = 1'b0; err_exp = 1'b0; last_fill_exp = '0;
    cur_n = 0; first_beat_n = -1; stalled = 1'b0; stab_viol = 0;
    test_reset();
    test_write_basic();
    test_fill_basic();
    test_backpressure();
    test_idle_rsp();
    test_protocol_err();
    test_reset_mid_write();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end

endmodule
